// File: rtl/mips_pkg.sv
// Shared MIPS definitions: default datapath widths and the register-file
// write arbiter state encoding.
package mips_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_ADDR_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Arbitrates register-file writes between the write-back stage and the debug
// unit; write-back has priority until the debug request starves, then the pipeline is stalled.
module regfile_write_arbiter
    import mips_pkg::*;
#(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int NB_ADDR    = NB_ADDR_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_wb_regWrite,
    input  logic [NB_ADDR-1:0] i_wb_reg2write,
    input  logic [NB_DATA-1:0] i_wb_write_data,
    input  logic               i_dbg_valid,
    input  logic [NB_ADDR-1:0] i_dbg_reg2write,
    input  logic [NB_DATA-1:0] i_dbg_write_data,
    output logic               o_dbg_ready,
    output logic               o_stall,
    output logic               o_regWrite,
    output logic [NB_ADDR-1:0] o_reg2write,
    output logic [NB_DATA-1:0] o_write_data
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    arb_state_e         r_state;
    arb_state_e         w_next_state;
    logic [3:0]         r_starve_cnt;
    logic [3:0]         w_next_cnt;
    logic               w_dbg_ready;
    logic               w_wr_req;
    logic [NB_ADDR-1:0] w_wr_addr;
    logic [NB_DATA-1:0] w_wr_data;
    logic               w_wr_real;

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_starve_cnt;
        w_dbg_ready  = 1'b0;
        w_wr_req     = 1'b0;
        w_wr_addr    = i_wb_reg2write;
        w_wr_data    = i_wb_write_data;

        case (r_state)
            ST_IDLE, ST_WAIT: begin
                w_dbg_ready = i_dbg_valid & ~i_wb_regWrite;
                if (i_wb_regWrite) begin
                    w_wr_req = 1'b1;
                end else if (w_dbg_ready) begin
                    w_wr_req  = 1'b1;
                    w_wr_addr = i_dbg_reg2write;
                    w_wr_data = i_dbg_write_data;
                end
                if (!i_dbg_valid || w_dbg_ready) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = 4'd0;
                end else begin
                    // Counter is zero in IDLE, so this also seeds the first blocked cycle.
                    w_next_cnt   = r_starve_cnt + 4'd1;
                    w_next_state = (w_next_cnt >= CNT_MAX) ? ST_STALL : ST_WAIT;
                end
            end
            ST_STALL: begin
                w_dbg_ready = i_dbg_valid;
                if (w_dbg_ready) begin
                    w_wr_req  = 1'b1;
                    w_wr_addr = i_dbg_reg2write;
                    w_wr_data = i_dbg_write_data;
                end
                if (!i_dbg_valid || w_dbg_ready) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = 4'd0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // Writes to register 0 complete their handshake but never reach the file.
    assign w_wr_real = w_wr_req && (w_wr_addr != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            o_regWrite   <= 1'b0;
            o_reg2write  <= '0;
            o_write_data <= '0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_next_cnt;
            o_regWrite   <= w_wr_real;
            if (w_wr_real) begin
                o_reg2write  <= w_wr_addr;
                o_write_data <= w_wr_data;
            end
        end
    end

    assign o_dbg_ready = w_dbg_ready;
    assign o_stall     = (r_state == ST_STALL);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, reset/abort
// sequences, then random traffic against a blocked-cycle-count model.
module tb_regfile_write_arbiter;

    localparam int NB_DATA    = 32;
    localparam int NB_ADDR    = 5;
    localparam int STARVE_MAX = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wb_we;
    logic [NB_ADDR-1:0] wb_reg;
    logic [NB_DATA-1:0] wb_data;
    logic               dbg_valid;
    logic [NB_ADDR-1:0] dbg_reg;
    logic [NB_DATA-1:0] dbg_data;
    logic               dbg_ready;
    logic               stall;
    logic               reg_we;
    logic [NB_ADDR-1:0] reg_addr;
    logic [NB_DATA-1:0] reg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NB_DATA   (NB_DATA),
        .NB_ADDR   (NB_ADDR),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk             (clk),
        .i_rst_n         (rst_n),
        .i_wb_regWrite   (wb_we),
        .i_wb_reg2write  (wb_reg),
        .i_wb_write_data (wb_data),
        .i_dbg_valid     (dbg_valid),
        .i_dbg_reg2write (dbg_reg),
        .i_dbg_write_data(dbg_data),
        .o_dbg_ready     (dbg_ready),
        .o_stall         (stall),
        .o_regWrite      (reg_we),
        .o_reg2write     (reg_addr),
        .o_write_data    (reg_data)
    );

    typedef struct {
        logic        wb;
        logic [4:0]  wb_r;
        logic [31:0] wb_d;
        logic        dv;
        logic [4:0]  dv_r;
        logic [31:0] dv_d;
        logic        e_ready;
        logic        e_stall;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wr, input logic [31:0] wd,
                         input logic d, input logic [4:0] dr, input logic [31:0] dd);
        wb_we = w; wb_reg = wr; wb_data = wd;
        dbg_valid = d; dbg_reg = dr; dbg_data = dd;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_data", reg_data, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Model: the arbiter is fully described by how many consecutive cycles the
    // current debug request has been blocked, plus the last real write.
    int          m_blocked;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_check_and_step();
        logic        stalled;
        logic        rdy;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wdat;
        stalled = (m_blocked >= STARVE_MAX);
        rdy     = dbg_valid && (stalled || !wb_we);
        check("rnd_ready", 32'(dbg_ready), 32'(rdy));
        check("rnd_stall", 32'(stall), 32'(stalled));
        check("rnd_we", 32'(reg_we), 32'(m_we));
        check("rnd_addr", 32'(reg_addr), 32'(m_addr));
        check("rnd_data", reg_data, m_data);
        wr = 1'b0; wa = wb_reg; wdat = wb_data;
        if (!stalled && wb_we) wr = 1'b1;
        else if (rdy) begin wr = 1'b1; wa = dbg_reg; wdat = dbg_data; end
        m_we = wr && (wa != 5'd0);
        if (m_we) begin m_addr = wa; m_data = wdat; end
        if (!dbg_valid || rdy) m_blocked = 0;
        else if (!stalled) m_blocked++;
    endtask

    initial begin
        //           wb   wb_r  wb_d          dv   dv_r  dv_d          rdy  stl  we   addr   data
        vecs[0]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b0,5'd0, 32'h0};
        vecs[1]  = '{1'b1, 5'd10, 32'h12345678,1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b0,5'd0, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b1,5'd10,32'h12345678};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd15, 32'h87654321,1'b1,1'b0,1'b0,5'd10,32'h12345678};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b1,5'd15,32'h87654321};
        vecs[5]  = '{1'b1, 5'd3,  32'hA3,      1'b1, 5'd4,  32'hB4,      1'b0,1'b0,1'b0,5'd15,32'h87654321};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd4,  32'hB4,      1'b1,1'b0,1'b1,5'd3, 32'hA3};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b1,5'd4, 32'hB4};
        vecs[8]  = '{1'b1, 5'd1,  32'h11,      1'b1, 5'd7,  32'h77,      1'b0,1'b0,1'b0,5'd4, 32'hB4};
        vecs[9]  = '{1'b1, 5'd2,  32'h22,      1'b1, 5'd7,  32'h77,      1'b0,1'b0,1'b1,5'd1, 32'h11};
        vecs[10] = '{1'b1, 5'd5,  32'h55,      1'b1, 5'd7,  32'h77,      1'b0,1'b0,1'b1,5'd2, 32'h22};
        vecs[11] = '{1'b1, 5'd6,  32'h66,      1'b1, 5'd7,  32'h77,      1'b0,1'b0,1'b1,5'd5, 32'h55};
        vecs[12] = '{1'b1, 5'd8,  32'h88,      1'b1, 5'd7,  32'h77,      1'b1,1'b1,1'b1,5'd6, 32'h66};
        vecs[13] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b1,5'd7, 32'h77};
        vecs[14] = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd0,  32'hFFFFFFFF,1'b1,1'b0,1'b0,5'd7, 32'h77};
        vecs[15] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b0,5'd7, 32'h77};
        vecs[16] = '{1'b1, 5'd0,  32'h5,       1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b0,5'd7, 32'h77};
        vecs[17] = '{1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,       1'b0,1'b0,1'b0,5'd7, 32'h77};

        do_reset();

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].wb, vecs[i].wb_r, vecs[i].wb_d, vecs[i].dv, vecs[i].dv_r, vecs[i].dv_d);
            #3;
            check($sformatf("vec%0d_ready", i), 32'(dbg_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d_we", i), 32'(reg_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_addr", i), 32'(reg_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_data", i), reg_data, vecs[i].e_data);
            @(posedge clk);
            #1;
        end

        // Reset while stalled: o_stall and o_regWrite clear without a clock edge.
        drive(1'b1, 5'd9, 32'hC0DE, 1'b1, 5'd12, 32'hD00D);
        for (int k = 1; k <= STARVE_MAX; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("pre_rst_stall%0d", k), 32'(stall), 32'(k == STARVE_MAX));
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_stall", 32'(stall), 32'd0);
        check("async_rst_we", 32'(reg_we), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        // Starvation count restarts from scratch after release.
        for (int k = 1; k <= STARVE_MAX; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_stall%0d", k), 32'(stall), 32'(k == STARVE_MAX));
        end
        #2;
        check("post_rst_ready", 32'(dbg_ready), 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_wr_addr", 32'(reg_addr), 32'd12);
        check("post_rst_unstall", 32'(stall), 32'd0);

        // Abort in WAIT clears the starvation count.
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd13, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd13, 32'h2);
        @(posedge clk);
        #1;
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd13, 32'h2);
        for (int k = 1; k <= STARVE_MAX; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_stall%0d", k), 32'(stall), 32'(k == STARVE_MAX));
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check("abort_in_stall", 32'(stall), 32'd0);

        // Random traffic against the model.
        do_reset();
        m_blocked = 0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        begin
            int          heavy;
            logic        d_v;
            logic [4:0]  d_r;
            logic [31:0] d_d;
            d_v = 1'b0; d_r = 5'd0; d_d = 32'd0; heavy = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c % 40 == 0) heavy = int'($urandom_range(0, 1));
                if (!d_v) begin
                    if ($urandom_range(0, 2) == 0) begin
                        d_v = 1'b1;
                        d_r = 5'($urandom_range(0, 31));
                        d_d = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    d_v = 1'b0;
                end
                drive((heavy != 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0),
                      5'($urandom_range(0, 31)), $urandom, d_v, d_r, d_d);
                #3;
                if (d_v && dbg_valid && dbg_ready) d_v = 1'b0;
                model_check_and_step();
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
